axis_header_insert_ctrl: RTL and testbench

Sequencing controller for AXI-Stream header insertion. It accepts one right-aligned header beat per packet and drives the shared `data_combiner` datapath beat by beat. It carries the combiner's overflow bytes as a residual into the next beat, and issues a flush beat after the packet's last input beat. The block sits between the upstream payload stream plus header source and the downstream AXI-Stream sink, and presents a registered output stage.

---
 rtl/axis_header_insert_ctrl_pkg.sv | 29 ++
 rtl/axis_header_insert_ctrl_if.sv | 43 ++++
 rtl/axis_header_insert_ctrl_data_combiner.sv | 59 +++++
 rtl/axis_header_insert_ctrl.sv | 149 ++++++++++++++
 tb/tb_axis_header_insert_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_header_insert_ctrl_pkg.sv
// Shared types and helpers for the AXI-Stream header insertion controller.
package axis_hdr_pkg;

    // Sequencing states: wait for header, stream payload, emit the leftover beat.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    // Widest keep vector the popcount helper accepts; callers zero-extend.
    localparam int KEEP_MAX_WD = 64;

    // Width of a byte-count field for a beat of the given number of bytes.
    function automatic int unsigned byte_cnt_wd(int unsigned bytes);
        return $clog2(bytes);
    endfunction

    // Number of set bits in a keep vector.
    function automatic int unsigned keep_popcount(logic [KEEP_MAX_WD-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < KEEP_MAX_WD; i++) begin
            cnt = cnt + int'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_header_insert_ctrl_if.sv
// Bundle of the payload, header and output streams of the header inserter.
interface axis_header_insert_ctrl_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    // Payload stream
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    // Header stream
    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD:0]    byte_insert_cnt;
    logic                    ready_insert;
    // Output stream
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    // Controller side
    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_out,
        output ready_in, ready_insert,
        output valid_out, data_out, keep_out, last_out
    );

    // Environment side (sources and sink)
    modport master (
        output valid_in, data_in, keep_in, last_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_out,
        input  ready_in, ready_insert,
        input  valid_out, data_out, keep_out, last_out
    );
endinterface

// File: rtl/axis_header_insert_ctrl_data_combiner.sv
// Joins an LSB-aligned residual with an MSB-aligned beat into one MSB-aligned
// output beat; bytes that do not fit are returned right-aligned as overflow.
module data_combiner
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic [DATA_WD-1:0]      data_1,
    input  logic [DATA_BYTE_WD-1:0] keep_1,
    input  logic [DATA_WD-1:0]      data_2,
    input  logic [DATA_BYTE_WD-1:0] keep_2,
    output logic [DATA_WD-1:0]      combined_data_1,
    output logic [DATA_BYTE_WD-1:0] combined_keep_1,
    output logic [DATA_WD-1:0]      combined_data_2,
    output logic [DATA_BYTE_WD-1:0] combined_keep_2,
    output logic                    overflow
);
    // Wide enough to hold the sum of two byte counts.
    localparam int CW = int'(byte_cnt_wd(DATA_BYTE_WD)) + 2;
    localparam logic [CW-1:0] BYTES = CW'(DATA_BYTE_WD);

    logic [CW-1:0]           n1;
    logic [CW-1:0]           n2;
    logic [CW-1:0]           total;
    logic [CW-1:0]           ov_cnt;
    logic [2*DATA_WD-1:0]    wide;
    logic [DATA_WD-1:0]      data_2_ralign;

    // Byte counts, concatenation shift and overflow split.
    always_comb begin
        n1     = CW'(keep_popcount(KEEP_MAX_WD'(keep_1)));
        n2     = CW'(keep_popcount(KEEP_MAX_WD'(keep_2)));
        total  = n1 + n2;
        // Push the residual's valid bytes up against the MSB; data_2 follows.
        wide   = {data_1, data_2} << {BYTES - n1, 3'b000};
        if (total > BYTES) begin
            overflow        = 1'b1;
            ov_cnt          = total - BYTES;
            combined_keep_1 = '1;
        end else begin
            overflow        = 1'b0;
            ov_cnt          = '0;
            combined_keep_1 = ~({DATA_BYTE_WD{1'b1}} >> total);
        end
        // Overflow is the tail of data_2's valid bytes, right-aligned.
        data_2_ralign   = data_2 >> {BYTES - n2, 3'b000};
        combined_keep_2 = ~({DATA_BYTE_WD{1'b1}} << ov_cnt);
    end

    // Zero every byte that its keep bit marks invalid.
    generate
        for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_byte
            assign combined_data_1[gi*8 +: 8] = wide[DATA_WD + gi*8 +: 8] & {8{combined_keep_1[gi]}};
            assign combined_data_2[gi*8 +: 8] = data_2_ralign[gi*8 +: 8] & {8{combined_keep_2[gi]}};
        end
    endgenerate

endmodule

// File: rtl/axis_header_insert_ctrl.sv
// AXI-Stream header insertion controller: one header beat per packet, payload
// merged behind it through a shared combiner, registered output stage.
module axis_header_insert_ctrl
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axis_header_insert_ctrl_if.slave  bus
);
    state_e                  state_q, state_d;
    logic [DATA_WD-1:0]      resid_data_q, resid_data_d;
    logic [DATA_BYTE_WD-1:0] resid_keep_q, resid_keep_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;

    logic                    load_en;
    logic                    ready_in_c;
    logic                    ready_insert_c;
    logic [DATA_BYTE_WD-1:0] comb_keep_2;
    logic [DATA_WD-1:0]      comb_data_1;
    logic [DATA_BYTE_WD-1:0] comb_keep_1;
    logic [DATA_WD-1:0]      comb_data_2;
    logic [DATA_BYTE_WD-1:0] comb_keep_2_out;
    logic                    comb_overflow;
    logic                    unused_byte_cnt;

    // The header byte count is redundant with keep_insert.
    assign unused_byte_cnt = ^bus.byte_insert_cnt;

    assign load_en = !valid_out_q || bus.ready_out;

    // In FLUSH the payload side contributes nothing, draining the residual.
    assign comb_keep_2 = (state_q == FLUSH) ? '0 : bus.keep_in;

    data_combiner #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_combiner (
        .data_1          (resid_data_q),
        .keep_1          (resid_keep_q),
        .data_2          (bus.data_in),
        .keep_2          (comb_keep_2),
        .combined_data_1 (comb_data_1),
        .combined_keep_1 (comb_keep_1),
        .combined_data_2 (comb_data_2),
        .combined_keep_2 (comb_keep_2_out),
        .overflow        (comb_overflow)
    );

    // Next-state, residual update and output-register load decisions.
    always_comb begin
        state_d        = state_q;
        resid_data_d   = resid_data_q;
        resid_keep_d   = resid_keep_q;
        valid_out_d    = valid_out_q;
        data_out_d     = data_out_q;
        keep_out_d     = keep_out_q;
        last_out_d     = last_out_q;
        ready_in_c     = 1'b0;
        ready_insert_c = 1'b0;

        // A held beat leaves when the sink takes it; a new load may replace it.
        if (load_en) begin
            valid_out_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                ready_insert_c = rst_n;
                if (bus.valid_insert && ready_insert_c) begin
                    resid_data_d = bus.data_insert;
                    resid_keep_d = bus.keep_insert;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                ready_in_c = load_en && rst_n;
                if (bus.valid_in && ready_in_c) begin
                    valid_out_d = 1'b1;
                    data_out_d  = comb_data_1;
                    if (!bus.last_in || comb_overflow) begin
                        // Full beat out; leftover bytes carry into the next one.
                        keep_out_d   = '1;
                        last_out_d   = 1'b0;
                        resid_data_d = comb_data_2;
                        resid_keep_d = comb_keep_2_out;
                        if (bus.last_in) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        keep_out_d   = comb_keep_1;
                        last_out_d   = 1'b1;
                        resid_data_d = '0;
                        resid_keep_d = '0;
                        state_d      = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (load_en) begin
                    valid_out_d  = 1'b1;
                    data_out_d   = comb_data_1;
                    keep_out_d   = comb_keep_1;
                    last_out_d   = 1'b1;
                    resid_data_d = '0;
                    resid_keep_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, residual and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            resid_data_q <= '0;
            resid_keep_q <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            keep_out_q   <= '0;
            last_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resid_data_q <= resid_data_d;
            resid_keep_q <= resid_keep_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            keep_out_q   <= keep_out_d;
            last_out_q   <= last_out_d;
        end
    end

    assign bus.ready_in     = ready_in_c;
    assign bus.ready_insert = ready_insert_c;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;

endmodule

// File: tb/tb_axis_header_insert_ctrl.sv
// Scoreboard bench for the header insertion controller.
module tb_axis_header_insert_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_header_insert_ctrl_if #(.DATA_WD(DW)) bus ();

    axis_header_insert_ctrl #(.DATA_WD(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    no_insert_chk = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        exp_q.push_back(b);
    endtask

    // Output monitor: one line per accepted output beat, compared to scoreboard.
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
            $display("out beat data=%h keep=%b last=%b", bus.data_out, bus.keep_out, bus.last_out);
            if (exp_q.size() == 0) begin
                check_val("sb_entries", 64'(exp_q.size()), 64'd1);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check_val("out_data", 64'(bus.data_out), 64'(e.d));
                check_val("out_keep", 64'(bus.keep_out), 64'(e.k));
                check_val("out_last", 64'(bus.last_out), 64'(e.l));
            end
        end
    end

    task automatic send_header(input logic [31:0] d, input logic [3:0] k);
        int n;
        bit hs;
        n = 0; hs = 1'b0;
        bus.valid_insert    = 1'b1;
        bus.data_insert     = d;
        bus.keep_insert     = k;
        bus.byte_insert_cnt = 3'($countones(k));
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = bus.ready_insert;
            @(posedge clk); #1;
            n++;
        end
        if (!hs) check_val("hdr_timeout", 64'd0, 64'd1);
        bus.valid_insert = 1'b0;
        $display("hdr data=%h keep=%b", d, k);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        bit hs;
        n = 0; hs = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = bus.ready_in;
            if (no_insert_chk) check_val("rdy_ins_busy", 64'(bus.ready_insert), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        if (!hs) check_val("beat_timeout", 64'd0, 64'd1);
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        $display("in beat data=%h keep=%b last=%b", d, k, l);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.valid_in = 0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 0;
        bus.valid_insert = 0; bus.data_insert = '0; bus.keep_insert = '0;
        bus.byte_insert_cnt = '0; bus.ready_out = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(bus.valid_out), 64'd0);
        check_val("rst_last",  64'(bus.last_out), 64'd0);
        check_val("rst_data",  64'(bus.data_out), 64'd0);
        check_val("rst_keep",  64'(bus.keep_out), 64'd0);
        check_val("rst_rdy_in", 64'(bus.ready_in), 64'd0);
        check_val("rst_rdy_ins", 64'(bus.ready_insert), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_rdy_ins", 64'(bus.ready_insert), 64'd1);
        check_val("idle_rdy_in",  64'(bus.ready_in), 64'd0);
        @(posedge clk); #1;

        // Test 1: overflowing packet with flush
        push_exp(32'hAABB1122, 4'b1111, 1'b0);
        push_exp(32'h33445566, 4'b1111, 1'b0);
        push_exp(32'h77880000, 4'b1100, 1'b1);
        send_header(32'h0000AABB, 4'b0011);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        check_val("t1_latency", 64'(bus.valid_out), 64'd1);
        send_beat(32'h55667788, 4'b1111, 1'b1);
        @(negedge clk);
        check_val("t1_flush_rdy_in",  64'(bus.ready_in), 64'd0);
        check_val("t1_flush_rdy_ins", 64'(bus.ready_insert), 64'd0);
        wait_drain();

        // Test 2: single beat, no flush
        push_exp(32'hAA112233, 4'b1111, 1'b1);
        send_header(32'h000000AA, 4'b0001);
        send_beat(32'h11223300, 4'b1110, 1'b1);
        check_val("t2_valid", 64'(bus.valid_out), 64'd1);
        @(negedge clk);
        check_val("t2_idle", 64'(bus.ready_insert), 64'd1);
        wait_drain();

        // Test 3: full-width header
        push_exp(32'hDEADBEEF, 4'b1111, 1'b0);
        push_exp(32'h12000000, 4'b1000, 1'b1);
        send_header(32'hDEADBEEF, 4'b1111);
        send_beat(32'h12345678, 4'b1000, 1'b1);
        wait_drain();

        // Test 4: backpressure on the first output beat
        push_exp(32'hAABB1122, 4'b1111, 1'b0);
        push_exp(32'h33445566, 4'b1111, 1'b0);
        push_exp(32'h77880000, 4'b1100, 1'b1);
        send_header(32'h0000AABB, 4'b0011);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        bus.ready_out = 1'b0;
        bus.valid_in = 1'b1; bus.data_in = 32'h55667788; bus.keep_in = 4'b1111; bus.last_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t4_hold_valid", 64'(bus.valid_out), 64'd1);
            check_val("t4_hold_data",  64'(bus.data_out), 64'hAABB1122);
            check_val("t4_hold_keep",  64'(bus.keep_out), 64'hF);
            check_val("t4_hold_last",  64'(bus.last_out), 64'd0);
            check_val("t4_rdy_in",     64'(bus.ready_in), 64'd0);
            @(posedge clk); #1;
        end
        bus.ready_out = 1'b1;
        send_beat(32'h55667788, 4'b1111, 1'b1);
        wait_drain();

        // Test 5: next header held valid during packet 1
        push_exp(32'hAABB1122, 4'b1111, 1'b0);
        push_exp(32'h33445566, 4'b1111, 1'b0);
        push_exp(32'h77880000, 4'b1100, 1'b1);
        push_exp(32'hAA112233, 4'b1111, 1'b1);
        send_header(32'h0000AABB, 4'b0011);
        bus.valid_insert = 1'b1; bus.data_insert = 32'h000000AA;
        bus.keep_insert = 4'b0001; bus.byte_insert_cnt = 3'd1;
        no_insert_chk = 1'b1;
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1111, 1'b1);
        no_insert_chk = 1'b0;
        @(negedge clk);
        check_val("t5_rdy_ins_flush", 64'(bus.ready_insert), 64'd0);
        @(posedge clk); #1;
        check_val("t5_rdy_ins_after", 64'(bus.ready_insert), 64'd1);
        send_header(32'h000000AA, 4'b0001);
        send_beat(32'h11223300, 4'b1110, 1'b1);
        wait_drain();

        // Test 6: reset after the first payload beat
        push_exp(32'hAABB1122, 4'b1111, 1'b0);
        send_header(32'h0000AABB, 4'b0011);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t6_rst_rdy_ins", 64'(bus.ready_insert), 64'd0);
        check_val("t6_rst_rdy_in",  64'(bus.ready_in), 64'd0);
        @(posedge clk); #1;
        check_val("t6_rst_valid", 64'(bus.valid_out), 64'd0);
        @(negedge clk);
        check_val("t6_rst_rdy_ins2", 64'(bus.ready_insert), 64'd0);
        check_val("t6_rst_valid2", 64'(bus.valid_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("t6_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        check_val("t6_rdy_ins", 64'(bus.ready_insert), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        push_exp(32'hAA112233, 4'b1111, 1'b1);
        send_header(32'h000000AA, 4'b0001);
        send_beat(32'h11223300, 4'b1110, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        check_val("final_sb", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
